flow_upsample_2x: RTL and testbench

Doubles the resolution of a dense optical-flow field between pyramid levels: 80x60 to 160x120 (level 0) or 160x120 to 320x240 (level 1). It reads each coarse flow vector once, scales it by 2, and writes it to the 2x2 block of fine pixels it covers (nearest-neighbour replication). It is the upsample engine driven by the pyramid control FSM's `upsample_start`/`upsample_level`, and its `done` feeds that FSM's `upsample_done`. It sits between the coarse-level L-K solve and the next level's warp.

---
 rtl/flow_upsample_2x.sv | 189 ++++++++++++++++++
 tb/tb_flow_upsample_2x.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_upsample_2x.sv
// 2x nearest-neighbour optical-flow upsampler between pyramid levels; each coarse vector is doubled
// and replicated into its 2x2 fine block. Define FLOW_UPSAMPLE_SAT_EN to saturate the doubling.
module flow_upsample_2x #(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240,
    parameter int unsigned FLOW_W       = 16,
    parameter int unsigned ADDR_W       = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            level,
    output logic                  busy,
    output logic                  done,
    output logic                  src_rd_en,
    output logic [ADDR_W-1:0]     src_rd_addr,
    input  logic [2*FLOW_W-1:0]   src_rd_data,
    output logic                  dst_wr_en,
    output logic [ADDR_W-1:0]     dst_wr_addr,
    output logic [2*FLOW_W-1:0]   dst_wr_data
);

    localparam int unsigned DATA_W   = 2 * FLOW_W;
    localparam int unsigned L0_WS_M1 = IMAGE_WIDTH / 4 - 1;
    localparam int unsigned L0_HS_M1 = IMAGE_HEIGHT / 4 - 1;
    localparam int unsigned L1_WS_M1 = IMAGE_WIDTH / 2 - 1;
    localparam int unsigned L1_HS_M1 = IMAGE_HEIGHT / 2 - 1;
    localparam int unsigned L0_WD    = IMAGE_WIDTH / 2;
    localparam int unsigned L1_WD    = IMAGE_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                level_q, level_d;
    logic [ADDR_W-1:0]   x_q, x_d;
    logic [ADDR_W-1:0]   y_q, y_d;
    logic [1:0]          k_q, k_d;
    logic [ADDR_W-1:0]   blk_base_q, blk_base_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                src_rd_en_q, src_rd_en_d;
    logic [ADDR_W-1:0]   src_rd_addr_q, src_rd_addr_d;
    logic                dst_wr_en_q, dst_wr_en_d;
    logic [ADDR_W-1:0]   dst_wr_addr_q, dst_wr_addr_d;
    logic [DATA_W-1:0]   dst_wr_data_q, dst_wr_data_d;

    logic [ADDR_W-1:0]   ws_m1;
    logic [ADDR_W-1:0]   hs_m1;
    logic [ADDR_W-1:0]   wd;
    logic                last_px;

    // Doubling of one signed component; saturating or wrapping depending on build
    function automatic logic [FLOW_W-1:0] dbl(input logic [FLOW_W-1:0] a);
`ifdef FLOW_UPSAMPLE_SAT_EN
        if (a[FLOW_W-1] != a[FLOW_W-2]) begin
            dbl = a[FLOW_W-1] ? {1'b1, {(FLOW_W-1){1'b0}}} : {1'b0, {(FLOW_W-1){1'b1}}};
        end else begin
            dbl = {a[FLOW_W-2:0], 1'b0};
        end
`else
        dbl = {a[FLOW_W-2:0], 1'b0};
`endif
    endfunction

    assign ws_m1   = level_q ? ADDR_W'(L1_WS_M1) : ADDR_W'(L0_WS_M1);
    assign hs_m1   = level_q ? ADDR_W'(L1_HS_M1) : ADDR_W'(L0_HS_M1);
    assign wd      = level_q ? ADDR_W'(L1_WD)    : ADDR_W'(L0_WD);
    assign last_px = (x_q == ws_m1) && (y_q == hs_m1);

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        x_d           = x_q;
        y_d           = y_q;
        k_d           = k_q;
        blk_base_d    = blk_base_q;
        src_rd_addr_d = src_rd_addr_q;
        dst_wr_addr_d = dst_wr_addr_q;
        dst_wr_data_d = dst_wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!level[1]) begin
                        state_d       = ST_READ;
                        level_d       = level[0];
                        x_d           = '0;
                        y_d           = '0;
                        k_d           = '0;
                        blk_base_d    = '0;
                        src_rd_addr_d = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                state_d       = ST_WRITE;
                k_d           = '0;
                dst_wr_data_d = {dbl(src_rd_data[DATA_W-1:FLOW_W]), dbl(src_rd_data[FLOW_W-1:0])};
            end
            ST_WRITE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    if (last_px) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d       = ST_READ;
                        src_rd_addr_d = src_rd_addr_q + ADDR_W'(1);
                        if (x_q == ws_m1) begin
                            x_d        = '0;
                            y_d        = y_q + ADDR_W'(1);
                            blk_base_d = blk_base_q + wd + ADDR_W'(2);
                        end else begin
                            x_d        = x_q + ADDR_W'(1);
                            blk_base_d = blk_base_q + ADDR_W'(2);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // 2x2 block order: (0,0), (1,0), (0,1), (1,1)
        if (state_d == ST_WRITE) begin
            unique case (k_d)
                2'd0: dst_wr_addr_d = blk_base_q;
                2'd1: dst_wr_addr_d = blk_base_q + ADDR_W'(1);
                2'd2: dst_wr_addr_d = blk_base_q + wd;
                2'd3: dst_wr_addr_d = blk_base_q + wd + ADDR_W'(1);
            endcase
        end

        busy_d      = (state_d == ST_READ) || (state_d == ST_WAIT) || (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        src_rd_en_d = (state_d == ST_READ);
        dst_wr_en_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            level_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            k_q           <= '0;
            blk_base_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            src_rd_en_q   <= 1'b0;
            src_rd_addr_q <= '0;
            dst_wr_en_q   <= 1'b0;
            dst_wr_addr_q <= '0;
            dst_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            x_q           <= x_d;
            y_q           <= y_d;
            k_q           <= k_d;
            blk_base_q    <= blk_base_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            src_rd_en_q   <= src_rd_en_d;
            src_rd_addr_q <= src_rd_addr_d;
            dst_wr_en_q   <= dst_wr_en_d;
            dst_wr_addr_q <= dst_wr_addr_d;
            dst_wr_data_q <= dst_wr_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign src_rd_en   = src_rd_en_q;
    assign src_rd_addr = src_rd_addr_q;
    assign dst_wr_en   = dst_wr_en_q;
    assign dst_wr_addr = dst_wr_addr_q;
    assign dst_wr_data = dst_wr_data_q;

endmodule

// File: tb/tb_flow_upsample_2x.sv
// Scoreboard bench for flow_upsample_2x on a reduced 64x48 image so both levels run to completion.
module tb_flow_upsample_2x;

    localparam int IW = 64;
    localparam int IH = 48;
    localparam int FW = 16;
    localparam int AW = 17;
    localparam int DST_MAX = IW * IH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        level = 2'd0;
    logic              busy, done, src_rd_en, dst_wr_en;
    logic [AW-1:0]     src_rd_addr, dst_wr_addr;
    logic [2*FW-1:0]   src_rd_data = '0;
    logic [2*FW-1:0]   dst_wr_data;

    flow_upsample_2x #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .FLOW_W(FW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .level(level),
        .busy(busy), .done(done),
        .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
        .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   a;
        logic [2*FW-1:0] d;
    } wr_t;

    wr_t             exp_q[$];
    int              vec = 0;
    int              err = 0;
    int              cyc = 0;
    int              t0 = 0;
    bit              mon_en = 1'b0;
    int              cur_ws = 16;
    int              cur_wd = 32;
    int              rd_count = 0;
    int              wr_count = 0;
    int              written[DST_MAX];
    logic [2*FW-1:0] wdata[DST_MAX];
    logic [AW-1:0]   last_addr = '0;
    logic [2*FW-1:0] last_data = '0;

    // Coarse field contents: {v,u}; a few fixed pixels for the directed checks
    function automatic logic [2*FW-1:0] pat(input int a);
        if (a == 0) return {16'hFFFD, 16'h0005};
        if (a == 5) return {16'h9000, 16'h7000};
        if (a == 6) return {16'h8000, 16'h7FFF};
        return {16'(a * 7 + 3), 16'(a * 13 + 16128)};
    endfunction

    function automatic logic [FW-1:0] xd(input logic [FW-1:0] c);
        int s;
        s = 2 * int'($signed(c));
`ifdef FLOW_UPSAMPLE_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return 16'(s);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Coarse buffer: one-cycle read latency
    always @(posedge clk) if (src_rd_en) src_rd_data <= pat(int'(src_rd_addr));

    // Scoreboard: reads push their four expected writes, writes pop and compare
    always @(negedge clk) begin
        if (mon_en && src_rd_en) begin
            int x, y;
            logic [2*FW-1:0] e;
            wr_t w;
            vec++;
            if (src_rd_addr !== AW'(rd_count)) begin
                err++;
                $display("FAIL rd_addr: got %0d want %0d", src_rd_addr, rd_count);
            end
            x = rd_count % cur_ws;
            y = rd_count / cur_ws;
            e = pat(rd_count);
            for (int dy = 0; dy < 2; dy++) begin
                for (int dx = 0; dx < 2; dx++) begin
                    w.a = AW'((2 * y + dy) * cur_wd + 2 * x + dx);
                    w.d = {xd(e[2*FW-1:FW]), xd(e[FW-1:0])};
                    exp_q.push_back(w);
                end
            end
            rd_count++;
        end
        if (mon_en && dst_wr_en) begin
            wr_t w;
            wr_count++;
            vec++;
            if (exp_q.size() == 0) begin
                err++;
                $display("FAIL wr_unexpected: got addr %0d data %h want no write", dst_wr_addr, dst_wr_data);
            end else begin
                w = exp_q.pop_front();
                if (dst_wr_addr !== w.a || dst_wr_data !== w.d) begin
                    err++;
                    $display("FAIL wr: got addr %0d data %h want addr %0d data %h",
                             dst_wr_addr, dst_wr_data, w.a, w.d);
                end
            end
            if (int'(dst_wr_addr) < DST_MAX) begin
                written[int'(dst_wr_addr)]++;
                wdata[int'(dst_wr_addr)] = dst_wr_data;
            end
            last_addr = dst_wr_addr;
            last_data = dst_wr_data;
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        rd_count = 0;
        wr_count = 0;
        for (int i = 0; i < DST_MAX; i++) begin
            written[i] = 0;
            wdata[i] = '0;
        end
    endtask

    task automatic start_run(input logic [1:0] lv);
        @(posedge clk); #1;
        start = 1'b1;
        level = lv;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        level = 2'd0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc - t0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++;
        if ({busy, done, src_rd_en, dst_wr_en} !== 4'b0) begin
            err++;
            $display("FAIL reset_strobes: got %b want 0000", {busy, done, src_rd_en, dst_wr_en});
        end
        vec++;
        if (src_rd_addr !== '0 || dst_wr_addr !== '0 || dst_wr_data !== '0) begin
            err++;
            $display("FAIL reset_buses: got %h %h %h want 0", src_rd_addr, dst_wr_addr, dst_wr_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Full run at one level; optionally pulses a stray start mid-run
    task automatic run_full(input logic [1:0] lv, input int ws, input int hs, input bit stray);
        int dcyc, bad, want;
        cur_ws = ws;
        cur_wd = 2 * ws;
        want = 6 * ws * hs + 1;
        clear_sb();
        mon_en = 1'b1;
        start_run(lv);
        @(negedge clk);
        vec++;
        if (src_rd_en !== 1'b1 || busy !== 1'b1) begin
            err++;
            $display("FAIL first_read: got en %b busy %b want 1 1", src_rd_en, busy);
        end
        if (stray) begin
            repeat (100) @(posedge clk);
            #1 start = 1'b1;
            level = 2'd1;
            @(posedge clk); #1;
            start = 1'b0;
            level = 2'd0;
        end
        wait_done(want + 20, dcyc);
        vec++;
        if (dcyc != want) begin
            err++;
            $display("FAIL done_cycle: got %0d want %0d", dcyc, want);
        end
        vec++;
        if (busy !== 1'b0) begin
            err++;
            $display("FAIL busy_at_done: got %b want 0", busy);
        end
        @(negedge clk);
        vec++;
        if (done !== 1'b0) begin
            err++;
            $display("FAIL done_width: got %b want 0", done);
        end
        vec++;
        if (rd_count != ws * hs || wr_count != 4 * ws * hs || exp_q.size() != 0) begin
            err++;
            $display("FAIL counts: got rd %0d wr %0d pend %0d want rd %0d wr %0d pend 0",
                     rd_count, wr_count, exp_q.size(), ws * hs, 4 * ws * hs);
        end
        bad = 0;
        for (int i = 0; i < 4 * ws * hs; i++) if (written[i] != 1) bad++;
        vec++;
        if (bad != 0) begin
            err++;
            $display("FAIL coverage: got %0d addresses not written exactly once want 0", bad);
        end
        mon_en = 1'b0;
    endtask

    task automatic test_level0_full();
        logic [2*FW-1:0] sat_want;
`ifdef FLOW_UPSAMPLE_SAT_EN
        sat_want = {16'h8000, 16'h7FFF};
`else
        sat_want = {16'h2000, 16'hE000};
`endif
        run_full(2'd0, IW / 4, IH / 4, 1'b1);
        vec++;
        if (wdata[0] !== 32'hFFFA_000A || wdata[1] !== 32'hFFFA_000A ||
            wdata[IW / 2] !== 32'hFFFA_000A || wdata[IW / 2 + 1] !== 32'hFFFA_000A) begin
            err++;
            $display("FAIL first_block: got %h %h %h %h want fffa000a", wdata[0], wdata[1],
                     wdata[IW / 2], wdata[IW / 2 + 1]);
        end
        vec++;
        if (wdata[10] !== sat_want) begin
            err++;
            $display("FAIL overflow: got %h want %h", wdata[10], sat_want);
        end
    endtask

    task automatic test_level1_full();
        logic [2*FW-1:0] e;
        e = pat(IW / 2 * IH / 2 - 1);
        run_full(2'd1, IW / 2, IH / 2, 1'b0);
        vec++;
        if (last_addr !== AW'(DST_MAX - 1) || last_data !== {xd(e[2*FW-1:FW]), xd(e[FW-1:0])}) begin
            err++;
            $display("FAIL last_write: got addr %0d data %h want addr %0d data %h",
                     last_addr, last_data, DST_MAX - 1, {xd(e[2*FW-1:FW]), xd(e[FW-1:0])});
        end
    endtask

    task automatic test_illegal_level();
        int dcyc;
        for (int lv = 2; lv < 4; lv++) begin
            clear_sb();
            mon_en = 1'b1;
            start_run(2'(lv));
            wait_done(10, dcyc);
            vec++;
            if (dcyc != 1) begin
                err++;
                $display("FAIL illegal_done: level %0d got cycle %0d want 1", lv, dcyc);
            end
            repeat (4) @(negedge clk);
            vec++;
            if (rd_count != 0 || wr_count != 0) begin
                err++;
                $display("FAIL illegal_access: got rd %0d wr %0d want 0 0", rd_count, wr_count);
            end
            mon_en = 1'b0;
        end
    endtask

    task automatic test_reset_midrun();
        int quiet_bad;
        clear_sb();
        cur_ws = IW / 4;
        cur_wd = IW / 2;
        mon_en = 1'b1;
        start_run(2'd0);
        while (cyc - t0 < 1000) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        vec++;
        if ({busy, done, src_rd_en, dst_wr_en} !== 4'b0) begin
            err++;
            $display("FAIL reset_midrun: got %b want 0000", {busy, done, src_rd_en, dst_wr_en});
        end
        mon_en = 1'b0;
        quiet_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (src_rd_en || dst_wr_en) quiet_bad++;
        end
        vec++;
        if (quiet_bad != 0) begin
            err++;
            $display("FAIL reset_quiet: got %0d active cycles want 0", quiet_bad);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_full(2'd0, IW / 4, IH / 4, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DST_MAX; i++) begin
            written[i] = 0;
            wdata[i] = '0;
        end
        test_reset();
        test_level0_full();
        test_illegal_level();
        test_level1_full();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
